cpu_control_unit: RTL

CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit
Interface
REQ-001 clk  input  1  system clock; all state changes occur on the rising edge.
REQ-002 clr  input  1  asynchronous, active-low reset.
REQ-003 IR  input  32  instruction from datapath IR; op=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
REQ-004 mem_ready  input  1  memory handshake: read data valid / write accepted.
REQ-005 Rin  output  16  one-hot general-register load enable (bit n = Rn_in).
REQ-006 Rout  output  16  one-hot general-register bus drive (bit n = Rn_out).
REQ-007 PCout  output  1  PC drives bus.
REQ-008 IncPC  output  1  PC increments.
REQ-009 MARin  output  1  MAR loads bus.
REQ-010 MDRin  output  1  MDR load enable.
REQ-011 MDRread  output  1  MDR source select: 1 = memory data, 0 = bus.
REQ-012 MDRout  output  1  MDR drives bus.
REQ-013 IRin  output  1  IR loads bus.
REQ-014 Yin  output  1  Y loads bus.
REQ-015 Zin  output  1  Z captures ALU result.
REQ-016 ZLOout  output  1  Z low word drives bus.
REQ-017 ZHIout  output  1  Z high word drives bus.
REQ-018 HIin  output  1  HI loads bus.
REQ-019 HIout  output  1  HI drives bus.
REQ-020 Loin  output  1  LO loads bus.
REQ-021 Loout  output  1  LO drives bus.
REQ-022 Cout  output  1  sign-extended constant IR[18:0] drives bus.
REQ-023 ALU_opcode  output  5  ALU operation select.
REQ-024 mem_read  output  1  memory read request.
REQ-025 mem_write  output  1  memory write request.
REQ-026 halted  output  1  high while in HALT.
Function
REQ-027 FSM states: RESET, T0..T7, HALT; outputs are Moore (function of state and IR only); every output not listed for a state SHALL be 0.
REQ-028 RESET->T0 on the first clk edge; fetch: T0 PCout,MARin,IncPC; T1 mem_read,MDRread,MDRin, held in T1 while mem_ready=0; T2 MDRout,IRin; then T3.
REQ-029 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, addi 01001, mul 01111, div 10000, mfhi 10111, mflo 11000, nop 11001, halt 11010; any other opcode executes as nop.
REQ-030 add/sub/and/or/shr/shl: T3 Rout[Rb],Yin; T4 Rout[Rc],Zin,ALU_opcode=op; T5 ZLOout,Rin[Ra].
REQ-031 addi: T3 Rout[Rb],Yin; T4 Cout,Zin,ALU_opcode=00011; T5 ZLOout,Rin[Ra]. ldi: T3 Cout,Rin[Ra].
REQ-032 ld: T3-T4 as addi; T5 ZLOout,MARin; T6 mem_read,MDRread,MDRin, held while mem_ready=0; T7 MDRout,Rin[Ra].
REQ-033 st: T3-T5 as ld; T6 Rout[Ra],MDRin (MDRread=0); T7 mem_write, held while mem_ready=0.
REQ-034 mul/div: T3 Rout[Ra],Yin; T4 Rout[Rb],Zin,ALU_opcode=op; T5 ZLOout,Loin; T6 ZHIout,HIin.
REQ-035 mfhi: T3 HIout,Rin[Ra]; mflo: T3 Loout,Rin[Ra]; nop: T3 with no outputs asserted.
REQ-036 halt: T3->HALT; HALT is absorbing (only clr exits); halted=1, all other outputs 0.
REQ-037 The last execute step of each instruction SHALL go to T0 on the next edge.
REQ-038 ALU_opcode SHALL be 00000 outside the T4 states listed in REQ-030/031/034.
REQ-039 mem_ready is sampled only in wait states; mem_ready=1 on first wait cycle gives a one-cycle step; mem_read and mem_write SHALL never both be 1.
REQ-040 Rin and Rout SHALL each have at most one bit set; Rin and Rout SHALL never both be nonzero in the same state.
Reset
REQ-041 clr=0 SHALL force RESET immediately (including mid-wait), with all outputs 0 combinationally and independent of clk.
REQ-042 Release of clr SHALL take effect synchronously: RESET->T0 on the following clk edge.
Structure
REQ-043 Package cpu_ctrl_pkg SHALL hold the opcode constants, the state enumeration and ALU_ADD=00011.
REQ-044 One sub-module, reg_select_decoder (4-bit index plus enable -> 16-bit one-hot), instantiated twice: once for Rin and once for Rout.
Verification
REQ-045 Reset: clr=0 while in T1 wait -> all outputs 0 in same cycle; release -> PCout=1 after first edge.
REQ-046 add R3,R1,R2 (IR=0x19890000), mem_ready=1 -> T3 Rout=0x0002,Yin; T4 Rout=0x0004,ALU_opcode=00011,Zin; T5 ZLOout,Rin=0x0008; six cycles T0->T0.
REQ-047 ld R2,0x55(R1) (IR=0x01080055), mem_ready=0 for 3 cycles in T6 -> mem_read held 4 cycles; T7 MDRout,Rin=0x0004.
REQ-048 mul R4,R5 (IR=0x7A280000) -> ALU_opcode=01111 only in T4; T5 ZLOout,Loin; T6 ZHIout,HIin.
REQ-049 halt (IR=0xD0000000) -> halted=1 from next edge; PCout stays 0 for 10 cycles; clr pulse -> halted=0, fetch restarts.

---
 rtl/cpu_ctrl_pkg.sv | 34 +++
 rtl/reg_select_decoder.sv | 13 +
 rtl/cpu_control_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired CPU control unit: opcodes, ALU selects
// and the control-step state encoding.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ADDI = 5'b01001;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  // Register-register ALU ops share the Rb->Y, Rc->ALU, Z->Ra sequence.
  function automatic logic is_alu_rr(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SHR) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-bit register index plus enable to a 16-bit one-hot register strobe.
module reg_select_decoder (
  input  logic [3:0]  idx,
  input  logic        en,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Hardwired Moore control unit: fetch (T0-T2), opcode-dependent execute (T3-T7),
// memory wait states in T1/T6/T7, and an absorbing HALT state.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCout,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRread,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        HIin,
  output logic        HIout,
  output logic        Loin,
  output logic        Loout,
  output logic        Cout,
  output logic [4:0]  ALU_opcode,
  output logic        mem_read,
  output logic        mem_write,
  output logic        halted
);

  state_e state_q, state_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic [3:0] rin_idx, rout_idx;
  logic       rin_en, rout_en;
  logic       muldiv;
  logic       unused_ir;

  assign op        = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign muldiv    = (op == OP_MUL) || (op == OP_DIV);
  assign unused_ir = ^IR[14:0];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_RESET;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    rin_idx    = ra;
    rin_en     = 1'b0;
    rout_idx   = ra;
    rout_en    = 1'b0;
    PCout      = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    MDRread    = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    ZLOout     = 1'b0;
    ZHIout     = 1'b0;
    HIin       = 1'b0;
    HIout      = 1'b0;
    Loin       = 1'b0;
    Loout      = 1'b0;
    Cout       = 1'b0;
    ALU_opcode = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    halted     = 1'b0;

    unique case (state_q)
      S_RESET: state_d = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        mem_read = 1'b1; MDRread = 1'b1; MDRin = 1'b1;
        if (mem_ready) state_d = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        state_d = S_T0;
        if (is_alu_rr(op) || op == OP_ADDI || op == OP_LD || op == OP_ST) begin
          rout_idx = rb; rout_en = 1'b1; Yin = 1'b1;
          state_d = S_T4;
        end else if (muldiv) begin
          rout_idx = ra; rout_en = 1'b1; Yin = 1'b1;
          state_d = S_T4;
        end else if (op == OP_LDI) begin
          Cout = 1'b1; rin_en = 1'b1;
        end else if (op == OP_MFHI) begin
          HIout = 1'b1; rin_en = 1'b1;
        end else if (op == OP_MFLO) begin
          Loout = 1'b1; rin_en = 1'b1;
        end else if (op == OP_HALT) begin
          state_d = S_HALT;
        end
      end
      S_T4: begin
        state_d = S_T5;
        Zin     = 1'b1;
        if (is_alu_rr(op)) begin
          rout_idx = rc; rout_en = 1'b1; ALU_opcode = op;
        end else if (muldiv) begin
          rout_idx = rb; rout_en = 1'b1; ALU_opcode = op;
        end else begin
          Cout = 1'b1; ALU_opcode = ALU_ADD;
        end
      end
      S_T5: begin
        ZLOout  = 1'b1;
        state_d = S_T6;
        if (op == OP_LD || op == OP_ST) begin
          MARin = 1'b1;
        end else if (muldiv) begin
          Loin = 1'b1;
        end else begin
          rin_en  = 1'b1;
          state_d = S_T0;
        end
      end
      S_T6: begin
        if (op == OP_LD) begin
          mem_read = 1'b1; MDRread = 1'b1; MDRin = 1'b1;
          if (mem_ready) state_d = S_T7;
        end else if (op == OP_ST) begin
          rout_en = 1'b1; MDRin = 1'b1;
          state_d = S_T7;
        end else begin
          ZHIout = 1'b1; HIin = 1'b1;
          state_d = S_T0;
        end
      end
      S_T7: begin
        if (op == OP_ST) begin
          mem_write = 1'b1;
          if (mem_ready) state_d = S_T0;
        end else begin
          MDRout = 1'b1; rin_en = 1'b1;
          state_d = S_T0;
        end
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_RESET;
    endcase
  end

  reg_select_decoder u_rin_dec (
    .idx    (rin_idx),
    .en     (rin_en),
    .onehot (Rin)
  );

  reg_select_decoder u_rout_dec (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (Rout)
  );

endmodule
